ram_initiator: RTL and testbench

Bus-side initiator for the on-chip RAM slave. It accepts single load/store requests from the core's memory stage, converts them into a one-cycle ReadEnable/WriteEnable pulse with address, data and size strobe, and waits for RamReadReady/RamWriteReady. It then returns a size-extracted, sign- or zero-extended load result, or a store acknowledge, on a valid/ready response channel. It sits between the LSU and the BusMatrix port that feeds the RAM.

---
 rtl/ram_init_pkg.sv | 51 +++++
 rtl/ram_load_extend.sv | 28 ++
 rtl/ram_initiator.sv | 176 +++++++++++++++++
 tb/tb_ram_initiator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_init_pkg.sv
// ram_init_pkg: shared types and constants for the RAM initiator.
//   - state_e     : initiator FSM state encoding
//   - SIZE_*      : request size codes (byte/half/word/dword)
//   - STRB_*      : one-hot size strobes driven on RamWriteStrb
//   - req_ctl_t   : request attributes kept for the life of a transaction
//   - TIMEOUT_CYCLES_DEFAULT : default WAIT timeout (used with RAM_INIT_TIMEOUT_EN)
package ram_init_pkg;

  localparam int unsigned XLEN                   = 64;
  localparam int unsigned SIZE_BITS              = 2;
  localparam int unsigned STRB_BITS              = 4;
  localparam int unsigned TMO_CNT_W              = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [SIZE_BITS-1:0] SIZE_B = 2'd0;
  localparam logic [SIZE_BITS-1:0] SIZE_H = 2'd1;
  localparam logic [SIZE_BITS-1:0] SIZE_W = 2'd2;
  localparam logic [SIZE_BITS-1:0] SIZE_D = 2'd3;

  localparam logic [STRB_BITS-1:0] STRB_B = 4'h1;
  localparam logic [STRB_BITS-1:0] STRB_H = 4'h2;
  localparam logic [STRB_BITS-1:0] STRB_W = 4'h4;
  localparam logic [STRB_BITS-1:0] STRB_D = 4'h8;

  // Attributes needed after the request handshake to steer completion.
  typedef struct packed {
    logic                 write;
    logic [SIZE_BITS-1:0] size;
    logic                 sext;
  } req_ctl_t;

  // Size code to one-hot strobe.
  function automatic logic [STRB_BITS-1:0] size_to_strb(input logic [SIZE_BITS-1:0] size);
    logic [STRB_BITS-1:0] strb;
    case (size)
      SIZE_B:  strb = STRB_B;
      SIZE_H:  strb = STRB_H;
      SIZE_W:  strb = STRB_W;
      default: strb = STRB_D;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ram_load_extend.sv
// ram_load_extend: combinational load-data extraction and extension.
// Takes the low 8/16/32/64 bits of the RAM word according to the size
// code and fills the upper bits with the field's top bit (sign) or zero.
// Ports:
//   data_i [63:0] : raw RAM read data
//   size_i [1:0]  : 0 byte, 1 half, 2 word, 3 dword
//   sign_i        : 1 sign-extends, 0 zero-extends
//   data_o [63:0] : extended result
module ram_load_extend
  import ram_init_pkg::*;
(
  input  logic [XLEN-1:0]      data_i,
  input  logic [SIZE_BITS-1:0] size_i,
  input  logic                 sign_i,
  output logic [XLEN-1:0]      data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SIZE_B:  data_o = {{56{sign_i & data_i[7]}},  data_i[7:0]};
      SIZE_H:  data_o = {{48{sign_i & data_i[15]}}, data_i[15:0]};
      SIZE_W:  data_o = {{32{sign_i & data_i[31]}}, data_i[31:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/ram_initiator.sv
// ram_initiator: converts single LSU load/store requests into one-cycle
// RAM read/write enable pulses, waits for the RAM ready, and returns the
// extended load data (or a store acknowledge) on a valid/ready channel.
// Optional feature macro: RAM_INIT_TIMEOUT_EN -- when defined, a WAIT
// that lasts TIMEOUT_CYCLES cycles without the matching ready ends with
// an error response (RspError = 1, RspData = 0).
// Ports:
//   ACLK, ARESETn                 : clock, synchronous active-low reset
//   ReqValid/ReqReady             : request handshake (ReqReady decodes IDLE)
//   ReqWrite, ReqAddr, ReqWData,
//   ReqSize, ReqSignExt           : request payload
//   RspValid/RspReady             : response handshake
//   RspData, RspError             : response payload
//   RamReadAddr, RamWriteAddr,
//   RamWriteData, RamWriteStrb    : RAM command payload (0 when unused)
//   ReadEnable, WriteEnable       : one-cycle RAM command pulses
//   RamReadData, RamReadReady,
//   RamWriteReady                 : RAM completion
module ram_initiator
  import ram_init_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [XLEN-1:0]      ReqAddr,
  input  logic [XLEN-1:0]      ReqWData,
  input  logic [SIZE_BITS-1:0] ReqSize,
  input  logic                 ReqSignExt,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [XLEN-1:0]      RspData,
  output logic                 RspError,
  output logic [XLEN-1:0]      RamReadAddr,
  output logic [XLEN-1:0]      RamWriteAddr,
  output logic [XLEN-1:0]      RamWriteData,
  output logic [STRB_BITS-1:0] RamWriteStrb,
  output logic                 ReadEnable,
  output logic                 WriteEnable,
  input  logic [XLEN-1:0]      RamReadData,
  input  logic                 RamReadReady,
  input  logic                 RamWriteReady
);

  state_e                state_q;
  req_ctl_t              req_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [XLEN-1:0]       rd_addr_q;
  logic [XLEN-1:0]       wr_addr_q;
  logic [XLEN-1:0]       wr_data_q;
  logic [STRB_BITS-1:0]  wr_strb_q;
  logic                  rsp_valid_q;
  logic [XLEN-1:0]       rsp_data_q;
  logic                  rsp_err_q;

  logic [XLEN-1:0]       load_ext_d;
  logic                  done_c;
  logic                  tmo_hit_c;

  // Extension of the live RAM data; sampled into RspData on read completion.
  ram_load_extend u_load_extend (
    .data_i (RamReadData),
    .size_i (req_q.size),
    .sign_i (req_q.sext),
    .data_o (load_ext_d)
  );

  // Only the ready matching the transaction direction completes it.
  assign done_c = req_q.write ? RamWriteReady : RamReadReady;

`ifdef RAM_INIT_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q;

  // Counts completed WAIT cycles; expiry is the TIMEOUT_CYCLES-th WAIT cycle.
  assign tmo_hit_c = (state_q == ST_WAIT) &&
                     (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 32'd1));

  // WAIT cycle counter; cleared in every other state.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign tmo_hit_c             = 1'b0;
`endif

  // Request acceptance decodes the state directly.
  assign ReqReady = (state_q == ST_IDLE);

  // Initiator FSM with registered RAM command and response outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Enables are single-cycle pulses.
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ReqValid) begin
            req_q.write <= ReqWrite;
            req_q.size  <= ReqSize;
            req_q.sext  <= ReqSignExt;
            rd_en_q     <= !ReqWrite;
            wr_en_q     <= ReqWrite;
            rd_addr_q   <= ReqWrite ? '0 : ReqAddr;
            wr_addr_q   <= ReqWrite ? ReqAddr : '0;
            wr_data_q   <= ReqWrite ? ReqWData : '0;
            wr_strb_q   <= ReqWrite ? size_to_strb(ReqSize) : '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A ready coinciding with expiry takes priority over the timeout.
          if (done_c || tmo_hit_c) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (done_c && !req_q.write) ? load_ext_d : '0;
            rsp_err_q   <= !done_c;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RspReady) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ReadEnable   = rd_en_q;
  assign WriteEnable  = wr_en_q;
  assign RamReadAddr  = rd_addr_q;
  assign RamWriteAddr = wr_addr_q;
  assign RamWriteData = wr_data_q;
  assign RamWriteStrb = wr_strb_q;
  assign RspValid     = rsp_valid_q;
  assign RspData      = rsp_data_q;
  assign RspError     = rsp_err_q;

endmodule

// File: tb/tb_ram_initiator.sv
// tb_ram_initiator: self-checking bench for ram_initiator. The stimulus
// process walks each transaction through its phases and publishes the
// outputs the DUT must show in every cycle; one compare process checks
// them on the falling edge. Define RAM_INIT_TIMEOUT_EN to also cover
// the timeout path (TIMEOUT_CYCLES = 8).
`timescale 1ns/1ps
module tb_ram_initiator;
  import ram_init_pkg::*;

  localparam int unsigned TMO = 8;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        sext;
  } txn_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        ReqValid, ReqReady, ReqWrite, ReqSignExt;
  logic [63:0] ReqAddr, ReqWData;
  logic [1:0]  ReqSize;
  logic        RspValid, RspReady, RspError;
  logic [63:0] RspData;
  logic [63:0] RamReadAddr, RamWriteAddr, RamWriteData, RamReadData;
  logic [3:0]  RamWriteStrb;
  logic        ReadEnable, WriteEnable, RamReadReady, RamWriteReady;

  always #5 ACLK = ~ACLK;

  ram_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqWrite      (ReqWrite),
    .ReqAddr       (ReqAddr),
    .ReqWData      (ReqWData),
    .ReqSize       (ReqSize),
    .ReqSignExt    (ReqSignExt),
    .RspValid      (RspValid),
    .RspReady      (RspReady),
    .RspData       (RspData),
    .RspError      (RspError),
    .RamReadAddr   (RamReadAddr),
    .RamWriteAddr  (RamWriteAddr),
    .RamWriteData  (RamWriteData),
    .RamWriteStrb  (RamWriteStrb),
    .ReadEnable    (ReadEnable),
    .WriteEnable   (WriteEnable),
    .RamReadData   (RamReadData),
    .RamReadReady  (RamReadReady),
    .RamWriteReady (RamWriteReady)
  );

  // Expected outputs for the current cycle.
  logic        e_req_ready, e_rd_en, e_wr_en, e_rsp_valid, e_rsp_err;
  logic [63:0] e_rd_addr, e_wr_addr, e_wdata, e_rsp_data;
  logic [3:0]  e_strb;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge ACLK) begin
    if (chk_en) begin
      chk("ReqReady",     64'(ReqReady),     64'(e_req_ready));
      chk("ReadEnable",   64'(ReadEnable),   64'(e_rd_en));
      chk("WriteEnable",  64'(WriteEnable),  64'(e_wr_en));
      chk("RamReadAddr",  RamReadAddr,       e_rd_addr);
      chk("RamWriteAddr", RamWriteAddr,      e_wr_addr);
      chk("RamWriteData", RamWriteData,      e_wdata);
      chk("RamWriteStrb", 64'(RamWriteStrb), 64'(e_strb));
      chk("RspValid",     64'(RspValid),     64'(e_rsp_valid));
      chk("RspError",     64'(RspError),     64'(e_rsp_err));
      if (e_rsp_valid) chk("RspData", RspData, e_rsp_data);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference load extension: mask the low 8<<size bits, optionally sign-fill.
  function automatic logic [63:0] model_ext(input logic [63:0] d, input logic [1:0] sz, input logic sx);
    int unsigned nb;
    logic [63:0] mask;
    logic [63:0] v;
    nb   = 8 << sz;
    mask = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v    = d & mask;
    if (sx && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic txn_t mk(input logic w, input logic [63:0] a, input logic [63:0] wd,
                              input logic [1:0] sz, input logic sx);
    txn_t t;
    t.write = w; t.addr = a; t.wdata = wd; t.size = sz; t.sext = sx;
    return t;
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic exp_idle();
    e_req_ready = 1'b1; e_rd_en = 1'b0; e_wr_en = 1'b0;
    e_rd_addr = '0; e_wr_addr = '0; e_wdata = '0; e_strb = '0;
    e_rsp_valid = 1'b0; e_rsp_err = 1'b0; e_rsp_data = '0;
  endtask

  // Command phase: pulse selects ISSUE (enable high) versus WAIT.
  task automatic exp_cmd(input txn_t t, input bit pulse);
    exp_idle();
    e_req_ready = 1'b0;
    e_rd_en     = pulse && !t.write;
    e_wr_en     = pulse && t.write;
    e_rd_addr   = t.write ? 64'd0 : t.addr;
    e_wr_addr   = t.write ? t.addr : 64'd0;
    e_wdata     = t.write ? t.wdata : 64'd0;
    e_strb      = t.write ? 4'(1 << t.size) : 4'd0;
  endtask

  task automatic exp_resp(input logic [63:0] d, input logic err);
    exp_idle();
    e_req_ready = 1'b0;
    e_rsp_valid = 1'b1;
    e_rsp_data  = d;
    e_rsp_err   = err;
  endtask

  task automatic clear_readies();
    RamReadReady = 1'b0; RamWriteReady = 1'b0;
  endtask

  // One full transaction; the matching ready lands in WAIT cycle delay+1.
  task automatic do_txn(input txn_t t, input logic [63:0] rdata, input int delay,
                        input int hold, input bit stray, input logic [63:0] exp_load);
    bit timed_out;
    timed_out = 1'b0;
    exp_idle();
    ReqValid = 1'b1; ReqWrite = t.write; ReqAddr = t.addr; ReqWData = t.wdata;
    ReqSize = t.size; ReqSignExt = t.sext;
    step();
    ReqValid = 1'b0; ReqAddr = {$urandom, $urandom}; ReqWData = {$urandom, $urandom};
    exp_cmd(t, 1'b1);
    if (stray) begin
      RamReadReady = !t.write; RamWriteReady = t.write;
    end
    step();
    clear_readies();
    for (int k = 1; ; k++) begin
      exp_cmd(t, 1'b0);
      RamReadData = {$urandom, $urandom};
      if (k == delay + 1) begin
        RamReadReady = !t.write; RamWriteReady = t.write; RamReadData = rdata;
      end else if (stray) begin
        RamReadReady = t.write; RamWriteReady = !t.write;
      end
      step();
      clear_readies();
      if (k == delay + 1) break;
`ifdef RAM_INIT_TIMEOUT_EN
      if (k == int'(TMO)) begin
        timed_out = 1'b1;
        break;
      end
`endif
    end
    for (int h = 0; h <= hold; h++) begin
      if (timed_out) exp_resp(64'd0, 1'b1);
      else           exp_resp(t.write ? 64'd0 : exp_load, 1'b0);
      RspReady      = (h == hold);
      ReqValid      = (h != hold);
      ReqWrite      = 1'($urandom);
      RamReadReady  = 1'($urandom);
      RamWriteReady = 1'($urandom);
      step();
    end
    RspReady = 1'b0; ReqValid = 1'b0;
    clear_readies();
  endtask

  // Reset during WAIT abandons the load; a late ready in IDLE is dropped.
  task automatic reset_in_wait();
    txn_t t;
    t = mk(1'b0, 64'h0000_0000_0000_0340, 64'd0, SIZE_W, 1'b0);
    exp_idle();
    ReqValid = 1'b1; ReqWrite = t.write; ReqAddr = t.addr; ReqSize = t.size; ReqSignExt = t.sext;
    step();
    ReqValid = 1'b0;
    exp_cmd(t, 1'b1);
    step();
    exp_cmd(t, 1'b0);
    step();
    exp_cmd(t, 1'b0);
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    exp_idle();
    RamReadReady = 1'b1; RamWriteReady = 1'b1;
    step();
    clear_readies();
    exp_idle();
    step();
  endtask

  initial begin
    ARESETn = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
    ReqSize = '0; ReqSignExt = 1'b0; RspReady = 1'b0; RamReadData = '0;
    clear_readies();
    step();
    step();
    exp_idle();
    chk_en = 1'b1;
    step();
    ARESETn = 1'b1;

    // Directed cases with hand-computed results.
    do_txn(mk(1'b0, 64'h100, 64'd0, SIZE_D, 1'b0), 64'h1122_3344_5566_7788, 2, 0, 1'b0,
           64'h1122_3344_5566_7788);
    do_txn(mk(1'b0, 64'h101, 64'd0, SIZE_B, 1'b1), 64'h1234_5678_9ABC_DE80, 1, 0, 1'b0,
           64'hFFFF_FFFF_FFFF_FF80);
    do_txn(mk(1'b0, 64'h101, 64'd0, SIZE_B, 1'b0), 64'h1234_5678_9ABC_DE80, 1, 0, 1'b0,
           64'h0000_0000_0000_0080);
    do_txn(mk(1'b1, 64'h208, 64'h0000_0000_0000_BEEF, SIZE_H, 1'b0), 64'd0, 1, 0, 1'b0, 64'd0);
    do_txn(mk(1'b0, 64'h2F0, 64'd0, SIZE_W, 1'b1), 64'hAAAA_AAAA_8000_1234, 0, 5, 1'b0,
           64'hFFFF_FFFF_8000_1234);
    do_txn(mk(1'b0, 64'h3F8, 64'd0, SIZE_H, 1'b1), 64'h0000_0000_0000_7FFF, 3, 0, 1'b1,
           64'h0000_0000_0000_7FFF);
`ifdef RAM_INIT_TIMEOUT_EN
    do_txn(mk(1'b0, 64'h500, 64'd0, SIZE_D, 1'b0), 64'h5555_5555_5555_5555, 20, 1, 1'b0, 64'd0);
    do_txn(mk(1'b0, 64'h508, 64'd0, SIZE_D, 1'b0), 64'h0123_4567_89AB_CDEF, 7, 0, 1'b0,
           64'h0123_4567_89AB_CDEF);
`endif
    reset_in_wait();

    // Randomized transactions against the reference extension.
    for (int n = 0; n < 200; n++) begin
      txn_t t;
      logic [63:0] rd;
      t  = mk(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              2'($urandom), 1'($urandom));
      rd = {$urandom, $urandom};
      do_txn(t, rd, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
             1'($urandom), model_ext(rd, t.size, t.sext));
    end

    exp_idle();
    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
